dds_sweep_ctrl: RTL and testbench
=================================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter ADDR_WIDTH, 7, phase width of the controlled counter.
REQ-003 Parameter INCR_WIDTH, 4, phase-increment width.
REQ-004 Parameter DWELL_WIDTH, 16, dwell-counter width.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  single-cycle pulse; launches a sweep.
REQ-008 abort  in  1  level; terminates the sweep.
REQ-009 pause  in  1  level; freezes the sweep.
REQ-010 cfg_phase  in  ADDR_WIDTH  preload phase.
REQ-011 cfg_incr_start  in  INCR_WIDTH  first increment.
REQ-012 cfg_incr_stop  in  INCR_WIDTH  final increment.
REQ-013 cfg_dwell  in  DWELL_WIDTH  enabled cycles per increment value.
REQ-014 cfg_updn  in  1  count direction passed to counter.
REQ-015 cfg_bounce  in  1  1 = sweep start->stop->start.
REQ-016 preload, enable, updn  out  1 each  counter controls.
REQ-017 pl_data  out  ADDR_WIDTH  counter preload value.
REQ-018 incr  out  INCR_WIDTH  counter increment.
REQ-019 busy  out  1  high in any state but IDLE.
REQ-020 done  out  1  one-cycle pulse at normal completion.

Function
REQ-021 SHALL implement states IDLE, LOAD, RUN, DONE; all outputs registered.
REQ-022 IDLE: start=1 and abort=0 -> latch all cfg_* and enter LOAD; start while busy SHALL be ignored.
REQ-023 LOAD lasts exactly one cycle: preload=1, pl_data=latched cfg_phase, enable=0, incr=cfg_incr_start; pause has no effect in LOAD.
REQ-024 Start sampled at edge N -> preload high in cycle N+1 -> enable high from cycle N+2.
REQ-025 RUN: enable=1 unless pause=1; dwell counter advances only on enabled cycles.
REQ-026 Each increment value SHALL be held for exactly max(cfg_dwell,1) enabled cycles; cfg_dwell=0 treated as 1.
REQ-027 Step direction: +1 if stop>=start, else -1; step magnitude always 1; incr SHALL never leave [min(start,stop), max(start,stop)].
REQ-028 start==stop: single value held for one dwell (two dwells never; bounce ignored).
REQ-029 Bounce: on reaching stop, reverse direction; stop value held for one dwell only; terminate after start value's dwell completes.
REQ-030 Sweep end -> DONE for one cycle: done=1, enable=0, then IDLE.
REQ-031 abort=1 in LOAD/RUN/DONE -> IDLE next cycle, enable=0, preload=0, done never asserted; abort beats pause and start.
REQ-032 updn SHALL equal latched cfg_updn while busy, 0 in IDLE.
REQ-033 incr SHALL retain its last value in IDLE.

Reset
REQ-034 reset SHALL force IDLE, dwell counter 0, preload=0, pl_data=0, enable=0, updn=0, incr=0, busy=0, done=0 on the next edge, overriding any state including mid-sweep.

Structure
REQ-035 Package dds_pkg SHALL hold the state enum and default ADDR_WIDTH, INCR_WIDTH, DWELL_WIDTH constants.
REQ-036 Dwell counting SHALL be a sub-module dwell_timer (load, count-enable, expire pulse).
REQ-037 Controller outputs SHALL connect directly to the existing counter's enable/updn/preload/pl_data/incr ports.

Verification
REQ-038 start, phase=5, incr 1->6, dwell=1000, no bounce -> preload 1 cycle with pl_data=5; incr 1..6 each held 1000 cycles; done at cycle 6002 after start.
REQ-039 incr 1->3, dwell=4, bounce=1 -> incr sequence 1,2,3,2,1, 20 enabled cycles, one done pulse.
REQ-040 incr 6->2, dwell=3 -> incr 6,5,4,3,2, 15 enabled cycles.
REQ-041 pause high 10 cycles mid-dwell (dwell=8) -> enable low 10 cycles, incr change delayed by exactly 10 cycles.
REQ-042 abort during RUN, and reset during RUN -> IDLE next cycle, enable=0, no done; second start during busy ignored.
REQ-043 dwell=0, start=stop=4 -> incr=4 for exactly 1 enabled cycle, then done.

Source files
------------

// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and default widths for the DDS sweep controller.
package dds_pkg;
  localparam int DDS_ADDR_WIDTH  = 7;
  localparam int DDS_INCR_WIDTH  = 4;
  localparam int DDS_DWELL_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;
endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep command/config inputs plus the phase-counter control outputs.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH  = DDS_ADDR_WIDTH,
  parameter int INCR_WIDTH  = DDS_INCR_WIDTH,
  parameter int DWELL_WIDTH = DDS_DWELL_WIDTH
);
  logic                   start;
  logic                   abort;
  logic                   pause;
  logic [ADDR_WIDTH-1:0]  cfg_phase;
  logic [INCR_WIDTH-1:0]  cfg_incr_start;
  logic [INCR_WIDTH-1:0]  cfg_incr_stop;
  logic [DWELL_WIDTH-1:0] cfg_dwell;
  logic                   cfg_updn;
  logic                   cfg_bounce;
  logic                   preload;
  logic                   enable;
  logic                   updn;
  logic [ADDR_WIDTH-1:0]  pl_data;
  logic [INCR_WIDTH-1:0]  incr;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, pause, cfg_phase, cfg_incr_start, cfg_incr_stop,
           cfg_dwell, cfg_updn, cfg_bounce,
    input  preload, enable, updn, pl_data, incr, busy, done
  );

  modport slave (
    input  start, abort, pause, cfg_phase, cfg_incr_start, cfg_incr_stop,
           cfg_dwell, cfg_updn, cfg_bounce,
    output preload, enable, updn, pl_data, incr, busy, done
  );
endinterface

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Down-counter measuring how many enabled cycles the current increment has been held.
module dwell_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cen,
  output logic             expire
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Expire fires on the enabled cycle that completes the dwell.
  assign expire = cen && (cnt_q == '0);

  // Load takes priority; otherwise count down on enabled cycles, parking at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (cen && cnt_q != '0) cnt_d = cnt_q - WIDTH'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Steps a phase counter's increment from start to stop (optionally back), holding
// each value for a programmable number of enabled cycles. All outputs are flops.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH  = DDS_ADDR_WIDTH,
  parameter int INCR_WIDTH  = DDS_INCR_WIDTH,
  parameter int DWELL_WIDTH = DDS_DWELL_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  dds_sweep_ctrl_if.slave bus
);
  state_e                 state_q, state_d;
  logic                   preload_q, preload_d, enable_q, enable_d;
  logic                   updn_q, updn_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]  pl_data_q, pl_data_d;
  logic [INCR_WIDTH-1:0]  incr_q, incr_d, first_q, first_d, stop_q, stop_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   bounce_q, bounce_d, dir_up_q, dir_up_d, back_q, back_d;
  logic                   tmr_load, tmr_cen, tmr_expire;
  logic [DWELL_WIDTH-1:0] tmr_val;
  logic [INCR_WIDTH-1:0]  turn_val;

  // A dwell of 0 behaves as 1, so the reload value clamps at zero.
  assign tmr_val  = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);
  // Only cycles where the counter is actually enabled consume dwell.
  assign tmr_cen  = (state_q == ST_RUN) && enable_q;
  // Outbound leg ends at stop, return leg ends back at the start value.
  assign turn_val = back_q ? first_q : stop_q;

  dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cen      (tmr_cen),
    .expire   (tmr_expire)
  );

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    preload_d = 1'b0;
    enable_d  = 1'b0;
    done_d    = 1'b0;
    pl_data_d = pl_data_q;
    incr_d    = incr_q;
    updn_d    = updn_q;
    first_d   = first_q;
    stop_d    = stop_q;
    dwell_d   = dwell_q;
    bounce_d  = bounce_q;
    dir_up_d  = dir_up_q;
    back_d    = back_q;
    tmr_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d   = ST_LOAD;
          preload_d = 1'b1;
          pl_data_d = bus.cfg_phase;
          incr_d    = bus.cfg_incr_start;
          updn_d    = bus.cfg_updn;
          first_d   = bus.cfg_incr_start;
          stop_d    = bus.cfg_incr_stop;
          dwell_d   = bus.cfg_dwell;
          bounce_d  = bus.cfg_bounce;
          dir_up_d  = (bus.cfg_incr_stop >= bus.cfg_incr_start);
          back_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        tmr_load = 1'b1;
        state_d  = ST_RUN;
        enable_d = 1'b1;
      end
      ST_RUN: begin
        enable_d = !bus.pause;
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (incr_q == turn_val) begin
            if (!back_q && bounce_q && (first_q != stop_q)) begin
              // Turn around: stop value has had its single dwell.
              back_d   = 1'b1;
              dir_up_d = !dir_up_q;
              incr_d   = dir_up_q ? incr_q - INCR_WIDTH'(1) : incr_q + INCR_WIDTH'(1);
            end else begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              enable_d = 1'b0;
            end
          end else begin
            incr_d = dir_up_q ? incr_q + INCR_WIDTH'(1) : incr_q - INCR_WIDTH'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      preload_d = 1'b0;
      enable_d  = 1'b0;
      done_d    = 1'b0;
      incr_d    = incr_q;
    end
    busy_d = (state_d != ST_IDLE);
    if (state_d == ST_IDLE) updn_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      preload_q <= 1'b0;
      enable_q  <= 1'b0;
      updn_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pl_data_q <= '0;
      incr_q    <= '0;
      first_q   <= '0;
      stop_q    <= '0;
      dwell_q   <= '0;
      bounce_q  <= 1'b0;
      dir_up_q  <= 1'b0;
      back_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      preload_q <= preload_d;
      enable_q  <= enable_d;
      updn_q    <= updn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pl_data_q <= pl_data_d;
      incr_q    <= incr_d;
      first_q   <= first_d;
      stop_q    <= stop_d;
      dwell_q   <= dwell_d;
      bounce_q  <= bounce_d;
      dir_up_q  <= dir_up_d;
      back_q    <= back_d;
    end
  end

  assign bus.preload = preload_q;
  assign bus.enable  = enable_q;
  assign bus.updn    = updn_q;
  assign bus.pl_data = pl_data_q;
  assign bus.incr    = incr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed-vector bench for dds_sweep_ctrl: sweeps, bounce, pause, abort, reset.
module tb_dds_sweep_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if bus ();
  dds_sweep_ctrl dut (.clk(clk), .reset(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int seq[$], hold[$], first[$], ex[$];
  int en_cnt, done_cnt, done_idx, pl_cnt, pl_val, pl_idx, end_idx, stall, updn_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare the recorded increment sequence against ex.
  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, seq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < seq.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), seq[i], ex[i]);
  endtask

  // Set config and raise start; the following posedge samples it.
  task automatic kick(input int ph, input int is, input int ie, input int dw,
                      input bit ud, input bit bn);
    @(negedge clk);
    bus.cfg_phase      = 7'(ph);
    bus.cfg_incr_start = 4'(is);
    bus.cfg_incr_stop  = 4'(ie);
    bus.cfg_dwell      = 16'(dw);
    bus.cfg_updn       = ud;
    bus.cfg_bounce     = bn;
    bus.start          = 1'b1;
  endtask

  // Observe one cycle per negedge (idx 1 = cycle after start edge) until busy drops.
  // Optional pause window, abort, reset and stray-start events are applied by idx.
  task automatic collect(input int budget, input int p_at, input int p_len,
                         input int a_at, input int r_at, input int s_at);
    int idx, k, last;
    bit have;
    seq.delete(); hold.delete(); first.delete();
    en_cnt = 0; done_cnt = 0; done_idx = -1; pl_cnt = 0; pl_val = -1; pl_idx = -1;
    end_idx = -1; stall = 0; updn_seen = -1; idx = 0; have = 0; last = 0;
    while (1) begin
      @(negedge clk);
      idx++;
      if (bus.preload) begin pl_cnt++; pl_idx = idx; pl_val = int'(bus.pl_data); end
      if (bus.enable) begin
        en_cnt++;
        if (!have || int'(bus.incr) != last) begin
          seq.push_back(int'(bus.incr)); hold.push_back(1); first.push_back(idx);
          last = int'(bus.incr); have = 1;
        end else begin
          k = hold.size() - 1;
          hold[k] = hold[k] + 1;
        end
      end else if (bus.busy && !bus.preload && !bus.done) stall++;
      if (bus.done) begin done_cnt++; done_idx = idx; end
      if (bus.busy) updn_seen = int'(bus.updn);
      if (!bus.busy) begin end_idx = idx; break; end
      if (idx >= budget) begin chk("timeout_busy", bus.busy, 0); break; end
      bus.pause = (idx >= p_at) && (idx < p_at + p_len);
      bus.abort = (idx == a_at);
      rst       = (idx == r_at);
      bus.start = (idx == s_at);
      if (idx == s_at) begin bus.cfg_phase = 7'd99; bus.cfg_incr_start = 4'd9; end
    end
    bus.pause = 1'b0; bus.abort = 1'b0; rst = 1'b0; bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
    bus.cfg_phase = '0; bus.cfg_incr_start = '0; bus.cfg_incr_stop = '0;
    bus.cfg_dwell = '0; bus.cfg_updn = 1'b0; bus.cfg_bounce = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_enable", bus.enable, 0);
    chk("rst_preload", bus.preload, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_incr", bus.incr, 0);
    chk("rst_pl_data", bus.pl_data, 0);
    chk("rst_updn", bus.updn, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Long up-sweep, phase 5, incr 1..6, dwell 1000.
    kick(5, 1, 6, 1000, 1'b1, 1'b0);
    collect(7000, -1, 0, -1, -1, -1);
    chk("t1_pl_idx", pl_idx, 1);
    chk("t1_pl_val", pl_val, 5);
    chk("t1_pl_cnt", pl_cnt, 1);
    ex = '{1, 2, 3, 4, 5, 6};
    chk_seq("t1_seq");
    for (int i = 0; i < hold.size(); i++) chk($sformatf("t1_hold[%0d]", i), hold[i], 1000);
    chk("t1_first_en", first.size() > 0 ? first[0] : -1, 2);
    chk("t1_en_cnt", en_cnt, 6000);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_idx", done_idx, 6002);
    chk("t1_end_idx", end_idx, 6003);
    chk("t1_updn", updn_seen, 1);
    chk("t1_idle_updn", bus.updn, 0);
    chk("t1_idle_incr", bus.incr, 6);

    // Bounce 1->3->1, dwell 4.
    kick(0, 1, 3, 4, 1'b0, 1'b1);
    collect(200, -1, 0, -1, -1, -1);
    ex = '{1, 2, 3, 2, 1};
    chk_seq("t2_seq");
    chk("t2_en_cnt", en_cnt, 20);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_idx", done_idx, 22);

    // Down-sweep 6->2, dwell 3.
    kick(3, 6, 2, 3, 1'b0, 1'b0);
    collect(200, -1, 0, -1, -1, -1);
    ex = '{6, 5, 4, 3, 2};
    chk_seq("t3_seq");
    chk("t3_en_cnt", en_cnt, 15);
    chk("t3_done_idx", done_idx, 17);
    chk("t3_updn", updn_seen, 0);

    // Pause for 10 cycles in the middle of the first dwell (dwell 8).
    kick(0, 1, 3, 8, 1'b1, 1'b0);
    collect(200, 4, 10, -1, -1, -1);
    chk("t4_stall", stall, 10);
    chk("t4_hold0", hold.size() > 0 ? hold[0] : -1, 8);
    chk("t4_first1", first.size() > 1 ? first[1] : -1, 20);
    chk("t4_en_cnt", en_cnt, 24);
    chk("t4_done_idx", done_idx, 36);

    // Stray start while running, then abort.
    kick(11, 1, 6, 4, 1'b1, 1'b0);
    collect(200, -1, 0, 7, -1, 3);
    chk("t5_end_idx", end_idx, 8);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_pl_cnt", pl_cnt, 1);
    chk("t5_seq0", seq.size() > 0 ? seq[0] : -1, 1);
    chk("t5_enable", bus.enable, 0);
    chk("t5_updn", bus.updn, 0);
    chk("t5_incr_kept", bus.incr, 2);

    // Reset in the middle of a sweep.
    kick(21, 3, 7, 4, 1'b1, 1'b0);
    collect(200, -1, 0, -1, 5, -1);
    chk("t6_end_idx", end_idx, 6);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_enable", bus.enable, 0);
    chk("t6_incr", bus.incr, 0);
    chk("t6_pl_data", bus.pl_data, 0);
    chk("t6_updn", bus.updn, 0);

    // Zero dwell with start == stop.
    kick(2, 4, 4, 0, 1'b0, 1'b0);
    collect(50, -1, 0, -1, -1, -1);
    ex = '{4};
    chk_seq("t7_seq");
    chk("t7_en_cnt", en_cnt, 1);
    chk("t7_done_idx", done_idx, 3);
    chk("t7_done_cnt", done_cnt, 1);

    // start == stop with bounce set: still a single dwell.
    kick(2, 4, 4, 2, 1'b0, 1'b1);
    collect(50, -1, 0, -1, -1, -1);
    chk("t8_en_cnt", en_cnt, 2);
    chk("t8_seq_len", seq.size(), 1);

    // Downward bounce 5->3->5, dwell 1.
    kick(0, 5, 3, 1, 1'b0, 1'b1);
    collect(50, -1, 0, -1, -1, -1);
    ex = '{5, 4, 3, 4, 5};
    chk_seq("t9_seq");
    chk("t9_en_cnt", en_cnt, 5);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
